// File: rtl/matrix_pkg.sv
// Shared types and constants for the 7x5 dot-matrix row scanner.
package matrix_pkg;

  localparam int ROWS   = 7;
  localparam int COLS   = 5;
  localparam int PIXELS = ROWS * COLS;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int PIX_W  = $clog2(PIXELS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam logic [ROWS-1:0] ROW_OFF = {ROWS{1'b1}};
  localparam logic [COLS-1:0] COL_OFF = '0;

  // Counter width sized for the longer of the two phases, never below one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic logic [COLS-1:0] row_pixels(input logic [PIXELS-1:0] f,
                                                 input logic [ROW_W-1:0]  r);
    logic [PIX_W-1:0] base;
    base = PIX_W'(r) * PIX_W'(COLS);
    return f[base +: COLS];
  endfunction

endpackage

// File: rtl/matrix_row_decoder.sv
// Row index to active-low one-hot row drive; combinational, registered by the parent.
module matrix_row_decoder
  import matrix_pkg::*;
(
  input  logic [ROW_W-1:0] row,
  input  logic             en,
  output logic [ROWS-1:0]  row_n
);

  always_comb begin
    row_n = ROW_OFF;
    for (int i = 0; i < ROWS; i++) begin
      if (en && (row == ROW_W'(i))) begin
        row_n[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-scanning LED matrix driver: snapshot a frame, then blank/drive each row in turn.
//
// Handshake: there is no valid/ready pair here. enable is a level; latch marks the
// edge where frame was sampled into the shadow register, frame_done marks the end of
// the last row's drive slot. Upstream may change frame freely between latch pulses.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int DRIVE_CYC = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic [PIXELS-1:0] frame,
  output logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col,
  output logic              latch,
  output logic              frame_done,
  output scan_state_t       state_dbg
);

  localparam int CW = cnt_width(DRIVE_CYC, BLANK_CYC);
  localparam logic [CW-1:0]    DRIVE_LAST = CW'(DRIVE_CYC - 1);
  localparam logic [CW-1:0]    BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

  scan_state_t       state;
  logic [ROW_W-1:0]  row;
  logic [CW-1:0]     cnt;
  logic [PIXELS-1:0] shadow;
  logic [ROWS-1:0]   dec_row_n;

  matrix_row_decoder u_row_decoder (
    .row   (row),
    .en    (1'b1),
    .row_n (dec_row_n)
  );

  assign state_dbg = state;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      row        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      row_n      <= ROW_OFF;
      col        <= COL_OFF;
      latch      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      latch      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          row_n <= ROW_OFF;
          col   <= COL_OFF;
          if (enable) begin
            state  <= BLANK;
            row    <= '0;
            cnt    <= '0;
            shadow <= frame;
            latch  <= 1'b1;
          end
        end

        BLANK: begin
          if (!enable) begin
            state <= IDLE;
            row   <= '0;
            cnt   <= '0;
            row_n <= ROW_OFF;
            col   <= COL_OFF;
          end else if (cnt == BLANK_LAST) begin
            state <= DRIVE;
            cnt   <= '0;
            row_n <= dec_row_n;
            col   <= row_pixels(shadow, row);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DRIVE: begin
          // Disable wins over a coincident wrap, so no pulses are emitted then.
          if (!enable) begin
            state <= IDLE;
            row   <= '0;
            cnt   <= '0;
            row_n <= ROW_OFF;
            col   <= COL_OFF;
          end else if (cnt == DRIVE_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            row_n <= ROW_OFF;
            col   <= COL_OFF;
            if (row == ROW_LAST) begin
              row        <= '0;
              shadow     <= frame;
              latch      <= 1'b1;
              frame_done <= 1'b1;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          row   <= '0;
          cnt   <= '0;
          row_n <= ROW_OFF;
          col   <= COL_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scenario bench for matrix_scan_driver with short drive/blank slots (frame period 42).
module tb_matrix_scan_driver;
  import matrix_pkg::*;

  localparam int D  = 4;
  localparam int B  = 2;
  localparam int RP = D + B;
  localparam int FP = ROWS * RP;
  localparam int W  = ROWS + COLS;

  logic              clk    = 1'b0;
  logic              nrst   = 1'b0;
  logic              enable = 1'b0;
  logic [PIXELS-1:0] frame  = '0;
  logic [ROWS-1:0]   row_n;
  logic [COLS-1:0]   col;
  logic              latch;
  logic              frame_done;
  scan_state_t       state_dbg;

  always #5 clk = ~clk;

  matrix_scan_driver #(.DRIVE_CYC(D), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .enable     (enable),
    .frame      (frame),
    .row_n      (row_n),
    .col        (col),
    .latch      (latch),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] lit_q[$];
  int lit_cyc_q[$];
  int len_q[$];
  int latch_q[$];
  int done_q[$];

  logic [ROWS-1:0] prev_row_n = '1;
  int run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation only: records lit rows, lit lengths and pulse times.
  always @(negedge clk) begin
    if (!nrst) begin
      prev_row_n <= ROW_OFF;
      run        <= 0;
    end else begin
      if (row_n !== ROW_OFF && row_n !== prev_row_n) begin
        lit_q.push_back({row_n, col});
        lit_cyc_q.push_back(cyc);
        run <= 1;
      end else if (row_n !== ROW_OFF) begin
        run <= run + 1;
      end
      if (row_n === ROW_OFF && prev_row_n !== ROW_OFF) len_q.push_back(run);
      if (latch === 1'b1) latch_q.push_back(cyc);
      if (frame_done === 1'b1) done_q.push_back(cyc);
      prev_row_n <= row_n;
    end
  end

  function automatic logic [W-1:0] exp_row(input logic [PIXELS-1:0] f, input int r);
    logic [ROWS-1:0] rn;
    rn    = '1;
    rn[r] = 1'b0;
    return {rn, f[r*COLS +: COLS]};
  endfunction

  function automatic logic [PIXELS-1:0] alt_frame();
    logic [PIXELS-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = (r % 2 == 0) ? 5'b10101 : 5'b01010;
    return f;
  endfunction

  function automatic logic [PIXELS-1:0] rand_frame();
    logic [2:0]  hi;
    logic [31:0] lo;
    hi = 3'($urandom_range(0, 7));
    lo = $urandom();
    return {hi, lo};
  endfunction

  task automatic clear_obs();
    exp_q.delete();
    lit_q.delete();
    lit_cyc_q.delete();
    len_q.delete();
    latch_q.delete();
    done_q.delete();
  endtask

  task automatic push_frame(input logic [PIXELS-1:0] f);
    for (int r = 0; r < ROWS; r++) exp_q.push_back(exp_row(f, r));
  endtask

  task automatic wait_lit(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (lit_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic go_idle();
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    clear_obs();
  endtask

  task automatic test_reset();
    bit bad;
    @(negedge clk); #1;
    checks++; if (row_n !== ROW_OFF) begin failures++; $display("FAIL reset_row_n got=%h exp=%h", row_n, ROW_OFF); end
    checks++; if (col !== COL_OFF) begin failures++; $display("FAIL reset_col got=%h exp=%h", col, COL_OFF); end
    checks++; if (latch !== 1'b0) begin failures++; $display("FAIL reset_latch got=%b exp=0", latch); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
    nrst = 1'b1;
    bad  = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      if (row_n !== ROW_OFF || col !== COL_OFF) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL idle_blank got=%h/%h exp=%h/%h", row_n, col, ROW_OFF, COL_OFF); end
    checks++; if (latch_q.size() + done_q.size() != 0) begin failures++; $display("FAIL idle_pulses got=%0d exp=0", latch_q.size() + done_q.size()); end
    clear_obs();
  endtask

  task automatic test_single_pixel();
    int k;
    bit ok;
    logic [W-1:0] e, g;
    frame  = 35'h1;
    k      = cyc + 1;
    enable = 1'b1;
    push_frame(frame);
    wait_lit(ROWS, 80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=%0d exp=%0d", lit_q.size(), ROWS); end
    checks++; if (latch_q.size() == 0 || latch_q[0] != k) begin failures++; $display("FAIL single_latch got=%0d exp=%0d", (latch_q.size() > 0) ? latch_q[0] : -1, k); end
    checks++; if (lit_cyc_q.size() == 0 || lit_cyc_q[0] != k + B) begin failures++; $display("FAIL single_first_lit got=%0d exp=%0d", (lit_cyc_q.size() > 0) ? lit_cyc_q[0] : -1, k + B); end
    checks++; if (len_q.size() == 0 || len_q[0] != D) begin failures++; $display("FAIL single_len got=%0d exp=%0d", (len_q.size() > 0) ? len_q[0] : -1, D); end
    while (exp_q.size() > 0 && lit_q.size() > 0) begin
      e = exp_q.pop_front();
      g = lit_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL single_row got=%h exp=%h", g, e); end
    end
    go_idle();
  endtask

  task automatic test_full_scan();
    int k;
    bit ok, bad_t, bad_l;
    logic [W-1:0] e, g;
    frame  = alt_frame();
    k      = cyc + 1;
    enable = 1'b1;
    push_frame(frame);
    push_frame(frame);
    ok = 1'b0;
    for (int i = 0; i < 2 * FP + 10; i++) begin
      @(negedge clk); #1;
      if (done_q.size() >= 2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || lit_q.size() < 2 * ROWS) begin failures++; $display("FAIL full_timeout got=%0d exp=%0d", lit_q.size(), 2 * ROWS); end
    bad_t = 1'b0;
    bad_l = 1'b0;
    for (int i = 0; i < lit_cyc_q.size() && i < 2 * ROWS; i++) if (lit_cyc_q[i] != k + B + i * RP) bad_t = 1'b1;
    for (int i = 0; i < len_q.size() && i < 2 * ROWS; i++) if (len_q[i] != D) bad_l = 1'b1;
    checks++; if (bad_t) begin failures++; $display("FAIL full_row_timing got=%0d exp=%0d", lit_cyc_q[1], k + B + RP); end
    checks++; if (bad_l) begin failures++; $display("FAIL full_row_len got=%0d exp=%0d", len_q[0], D); end
    checks++; if (latch_q.size() < 3 || latch_q[1] != k + FP || latch_q[2] != k + 2 * FP) begin failures++; $display("FAIL full_latch_period got=%0d exp=%0d", (latch_q.size() > 1) ? latch_q[1] : -1, k + FP); end
    checks++; if (done_q.size() < 2 || done_q[0] != k + FP || done_q[1] != k + 2 * FP) begin failures++; $display("FAIL full_done_period got=%0d exp=%0d", (done_q.size() > 0) ? done_q[0] : -1, k + FP); end
    while (exp_q.size() > 0 && lit_q.size() > 0) begin
      e = exp_q.pop_front();
      g = lit_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL full_row got=%h exp=%h", g, e); end
    end
    go_idle();
  endtask

  task automatic test_tear_free();
    int k;
    bit ok;
    logic [W-1:0] e, g;
    frame  = alt_frame();
    k      = cyc + 1;
    enable = 1'b1;
    push_frame(frame);
    wait_lit(4, 60, ok);
    frame = '1;
    push_frame(frame);
    wait_lit(2 * ROWS, 2 * FP, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tear_timeout got=%0d exp=%0d", lit_q.size(), 2 * ROWS); end
    checks++; if (latch_q.size() < 2 || lit_cyc_q.size() < 8 || latch_q[1] != k + FP || lit_cyc_q[7] <= latch_q[1]) begin failures++; $display("FAIL tear_latch_order got=%0d exp=%0d", (latch_q.size() > 1) ? latch_q[1] : -1, k + FP); end
    while (exp_q.size() > 0 && lit_q.size() > 0) begin
      e = exp_q.pop_front();
      g = lit_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL tear_row got=%h exp=%h", g, e); end
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [W-1:0] e, g;
    frame  = rand_frame();
    enable = 1'b1;
    push_frame(frame);
    wait_lit(2, 30, ok);
    frame = rand_frame();
    push_frame(frame);
    wait_lit(2 * ROWS, 2 * FP, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d exp=%0d", lit_q.size(), 2 * ROWS); end
    while (exp_q.size() > 0 && lit_q.size() > 0) begin
      e = exp_q.pop_front();
      g = lit_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL b2b_row got=%h exp=%h", g, e); end
    end
    go_idle();
  endtask

  task automatic test_disable_mid();
    int k;
    bit ok;
    logic [W-1:0] e, g;
    frame  = alt_frame();
    enable = 1'b1;
    wait_lit(5, 60, ok);
    checks++; if (!ok || lit_q[4] !== exp_row(frame, 4)) begin failures++; $display("FAIL dis_mid_row4 got=%h exp=%h", (lit_q.size() > 4) ? lit_q[4] : '0, exp_row(frame, 4)); end
    enable = 1'b0;
    @(negedge clk); #1;
    checks++; if (row_n !== ROW_OFF || col !== COL_OFF) begin failures++; $display("FAIL dis_mid_blank got=%h/%h exp=%h/%h", row_n, col, ROW_OFF, COL_OFF); end
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL dis_mid_state got=%0d exp=%0d", state_dbg, IDLE); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (done_q.size() != 0 || latch_q.size() != 1) begin failures++; $display("FAIL dis_mid_pulses got=%0d/%0d exp=0/1", done_q.size(), latch_q.size()); end
    clear_obs();
    k      = cyc + 1;
    enable = 1'b1;
    exp_q.push_back(exp_row(frame, 0));
    wait_lit(1, 10, ok);
    checks++; if (!ok || lit_cyc_q[0] != k + B) begin failures++; $display("FAIL reenable_time got=%0d exp=%0d", (lit_cyc_q.size() > 0) ? lit_cyc_q[0] : -1, k + B); end
    checks++; if (latch_q.size() == 0 || latch_q[0] != k) begin failures++; $display("FAIL reenable_latch got=%0d exp=%0d", (latch_q.size() > 0) ? latch_q[0] : -1, k); end
    if (lit_q.size() > 0) begin
      e = exp_q.pop_front();
      g = lit_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL reenable_row got=%h exp=%h", g, e); end
    end
    go_idle();
  endtask

  task automatic test_disable_wrap();
    frame  = alt_frame();
    enable = 1'b1;
    repeat (FP) @(negedge clk);
    #1;
    checks++; if (row_n !== 7'h3F || col !== 5'b10101) begin failures++; $display("FAIL wrap_last_row got=%h/%h exp=%h/%h", row_n, col, 7'h3F, 5'b10101); end
    frame  = '1;
    enable = 1'b0;
    @(negedge clk); #1;
    checks++; if (latch !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL wrap_pulses got=%b%b exp=00", latch, frame_done); end
    checks++; if (state_dbg !== IDLE || row_n !== ROW_OFF || col !== COL_OFF) begin failures++; $display("FAIL wrap_idle got=%0d/%h exp=%0d/%h", state_dbg, row_n, IDLE, ROW_OFF); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (done_q.size() != 0 || latch_q.size() != 1) begin failures++; $display("FAIL wrap_pulse_count got=%0d/%0d exp=0/1", done_q.size(), latch_q.size()); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    bit ok, bad;
    frame  = alt_frame();
    enable = 1'b1;
    wait_lit(3, 40, ok);
    checks++; if (!ok || lit_q[2] !== exp_row(frame, 2)) begin failures++; $display("FAIL rst_mid_row2 got=%h exp=%h", (lit_q.size() > 2) ? lit_q[2] : '0, exp_row(frame, 2)); end
    #2;
    nrst = 1'b0;
    #1;
    checks++; if (row_n !== ROW_OFF || col !== COL_OFF) begin failures++; $display("FAIL rst_mid_async got=%h/%h exp=%h/%h", row_n, col, ROW_OFF, COL_OFF); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    nrst = 1'b1;
    clear_obs();
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      if (row_n !== ROW_OFF || col !== COL_OFF) bad = 1'b1;
    end
    checks++; if (bad || latch_q.size() + done_q.size() != 0) begin failures++; $display("FAIL rst_mid_after got=%0d exp=0", latch_q.size() + done_q.size()); end
    clear_obs();
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_full_scan();
    test_tear_free();
    test_back_to_back();
    test_disable_mid();
    test_disable_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
